// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: arbiter FSM states and byte/guard sizing.
package uart_pkg;

  localparam int UART_BYTE_W        = 8;
  localparam int UART_GUARD_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_HOLD = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: one-hot grant to the first requester at or after ptr, wrapping modulo N.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 any
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = PW'((int'(ptr) + k) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

  assign any = w_found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uarttx serializer among N byte-stream requesters.
// Handshakes: a byte moves on a rising edge where valid and ready are both high; the source holds it stable until then.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N     = 4,
  parameter int GUARD = UART_GUARD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N*UART_BYTE_W-1:0]   req__data,
  input  logic [N-1:0]               req__valid,
  input  logic [N-1:0]               req__last,
  output logic [N-1:0]               req__ready,
  output logic [UART_BYTE_W-1:0]     tx__data,
  output logic                       tx__valid,
  input  logic                       tx__ready,
  output logic [N-1:0]               grant,
  output logic                       busy,
  output uart_state_t                o_dbg_state,
  output logic [$clog2(N)-1:0]       o_dbg_ptr
);

  localparam int PW = $clog2(N);
  localparam int GW = $clog2(GUARD + 1);

  uart_state_t            r_state, w_state_nxt;
  logic [PW-1:0]          r_ptr, w_ptr_nxt;
  logic [N-1:0]           r_grant, w_grant_nxt;
  logic                   r_tx_valid, w_tx_valid_nxt;
  logic [UART_BYTE_W-1:0] r_tx_data, w_tx_data_nxt;
  logic                   r_hold_last, w_hold_last_nxt;
  logic [GW-1:0]          r_guard, w_guard_nxt;
  logic                   r_busy;

  logic [N-1:0]           w_pick_gnt;
  logic                   w_pick_any;
  logic [UART_BYTE_W-1:0] w_sel_data;
  logic                   w_sel_last;
  logic [PW-1:0]          w_gidx;
  logic                   w_sel_valid;

  rr_pick #(.N(N)) u_pick (
    .req (req__valid),
    .ptr (r_ptr),
    .gnt (w_pick_gnt),
    .any (w_pick_any)
  );

  // Mux the owner's byte, last flag and index out of the flat request bus.
  always_comb begin
    w_sel_data = '0;
    w_sel_last = 1'b0;
    w_gidx     = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_sel_data = req__data[i*UART_BYTE_W +: UART_BYTE_W];
        w_sel_last = req__last[i];
        w_gidx     = PW'(i);
      end
    end
  end

  assign w_sel_valid = |(req__valid & r_grant);

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_tx_valid_nxt  = r_tx_valid;
    w_tx_data_nxt   = r_tx_data;
    w_hold_last_nxt = r_hold_last;
    w_guard_nxt     = r_guard;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          w_grant_nxt = w_pick_gnt;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_sel_valid) begin
          w_tx_data_nxt   = w_sel_data;
          w_hold_last_nxt = w_sel_last;
          w_tx_valid_nxt  = 1'b1;
          w_state_nxt     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx__ready) begin
          w_tx_valid_nxt = 1'b0;
          w_guard_nxt    = GW'(GUARD);
          w_state_nxt    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // The serializer's ready lingers one cycle past an accept, so it is not looked at here.
        w_guard_nxt = r_guard - GW'(1);
        if (r_guard <= GW'(1)) begin
          if (r_hold_last) begin
            w_ptr_nxt   = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + PW'(1);
            w_grant_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_LOAD;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_hold_last <= 1'b0;
      r_guard     <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_hold_last <= w_hold_last_nxt;
      r_guard     <= w_guard_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  assign req__ready  = (r_state == ST_LOAD) ? r_grant : '0;
  assign tx__data    = r_tx_data;
  assign tx__valid   = r_tx_valid;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uarttx` serializer between `N` byte-stream requesters. Round-robin arbitration runs at message granularity: a grant locks to one requester until that requester delivers a byte flagged `last`. The block sits between the protocol engines that produce UART messages and the single `uarttx` instance. It drives the serializer's `in__data`/`in__valid` and observes its `out__ready`.

## Interface
- `N`, 4, number of requesters (2..8)
- `GUARD`, 2, idle cycles after each serializer accept before `tx__ready` is sampled again (≥1)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `req__data`  in  N*8  byte from requester i in bits [8i+7:8i]
- `req__valid`  in  N  requester i has a byte
- `req__last`  in  N  byte from requester i ends its message
- `req__ready`  out  N  one-hot; byte from requester i accepted when `req__valid[i] && req__ready[i]`
- `tx__data`  out  8  to `uarttx.in__data`
- `tx__valid`  out  1  to `uarttx.in__valid`
- `tx__ready`  in  1  from `uarttx.out__ready`
- `grant`  out  N  one-hot current owner; 0 when idle
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, SEND, HOLD.
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE, `ptr`=0, `grant`=0, `tx__valid`=0, `tx__data`=0, `busy`=0
  - holding byte=0, `hold_last`=0, guard counter=0
- `req__ready` is 0 during reset.
- IDLE:
  - If any `req__valid` is high, pick the first index at or after `ptr`, wrapping modulo N.
  - Register the choice in `grant` and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `req__ready = grant`. This output depends only on state and `grant`, never on `req__valid`.
  - On handshake: capture the byte into `tx__data`, capture `req__last[g]` into `hold_last`, then go to SEND.
  - With no handshake, stay in LOAD. The lock is held and other requesters are ignored.
- SEND:
  - `tx__valid`=1 with `tx__data` stable.
  - When `tx__ready`=1, drop `tx__valid`, load the guard counter with GUARD, and go to HOLD.
- HOLD:
  - Decrement the guard counter each cycle; `tx__ready` is ignored.
  - The guard exists because the serializer keeps `out__ready` high for one cycle after it accepts a byte.
  - When the counter reaches 0: if `hold_last`, set `ptr=(g+1) mod N`, clear `grant`, and go to IDLE. Otherwise go to LOAD.
- `ptr` update: advances only at message end and wraps from N-1 to 0.
- Lock: changes to `req__valid` on non-granted requesters have no effect until the granted message ends.
- A granted requester that drops `req__valid` mid-message stalls in LOAD indefinitely. This is intended; there is no timeout.
- Reset mid-message: returns to IDLE immediately. The partial message is abandoned, and the next grant starts from index 0.

## Timing
- All outputs except `req__ready` are registered. `req__ready` is a decode of registered state and `grant`.
- Idle request to `req__ready`: 1 cycle.
  - Cycle 0: IDLE sees `req__valid`.
  - Cycle 1: LOAD, handshake.
  - Cycle 2: `tx__valid`=1.
- Minimum SEND time is 1 cycle when `tx__ready` is already high.
- Per byte, minimum 2+GUARD cycles from LOAD to the next LOAD: LOAD, SEND, then GUARD cycles in HOLD.
- End of message to next grant:
  - Cycle after HOLD expiry: IDLE.
  - Following cycle: LOAD of the new owner.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins, with wrap-around.
- Requester valid and last in the same byte: the message is a single byte.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE/LOAD/SEND/HOLD)
  - `UART_BYTE_W`=8
  - `UART_GUARD_DEFAULT`=2
- Sub-module `rr_pick`: combinational N-way rotating-priority picker.
  - Inputs: `req` (N), `ptr` (clog2 N).
  - Outputs: one-hot `gnt` and `any`.
- Everything else is in the top level: FSM, holding register, guard counter.

## Test plan
- Single byte: requester 1 sends 0x55 with last, `tx__ready`=1.
  - `req__ready[1]` high in cycle 1.
  - `tx__valid` high in cycle 2 with `tx__data`=0x55.
  - `grant`=0 and `busy`=0 by cycle 6 with GUARD=2.
  - `ptr`=2.
- Contention: requesters 0 and 2 both present 2-byte messages (0xA0,0xA1 / 0xC0,0xC1) from reset.
  - `tx__data` sequence is A0,A1,C0,C1.
  - The second requester is granted only after A1's HOLD expires.
- Lock: during requester 3's message, requester 0 raises valid and requester 3 drops valid for 5 cycles.
  - Arbiter waits in LOAD with `grant`=0b1000.
  - Requester 0 is served after requester 3's last byte.
  - Then `ptr` wraps to 0.
- Serializer backpressure: `tx__ready`=0 for 100 cycles during SEND.
  - `tx__valid` and `tx__data` are held stable.
  - Exactly one accept occurs when `tx__ready` rises.
  - `tx__ready` held high through HOLD does not cause a second accept.
- Reset mid-SEND: assert `rst`=0 asynchronously.
  - `tx__valid`, `grant`, and `busy` go to 0 without waiting for a clock edge.
  - After release, requesters 2 and 3 both pending → requester 2 granted (`ptr`=0).
- Wrap fairness: N=4, all four requesters continuously send 1-byte messages.
  - Grant order is 0,1,2,3,0,1…
  - No requester waits more than 3 messages.
